// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//
// Contents:
//   N_REQ        number of requesters (fixed at 4, one per mux leg)
//   arb_state_e  arbiter FSM states: ARB (free to choose) / LOCK (packet in flight)
//   rr_pick      rotate-priority search: returns {found, idx} where idx is the first
//                asserted valid bit starting at ptr and wrapping modulo 4
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] valid,
                                         input logic [1:0]       ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest candidate back to ptr so the nearest hit is written last.
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Purely combinational rotate-priority encoder used by mux4_rr_arbiter.
//
// Ports:
//   valid  in  4  request vector
//   ptr    in  2  index with highest priority this cycle
//   found  out 1  at least one request is asserted
//   idx    out 2  chosen requester (0 when nothing is found)
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  logic [2:0] pick;

  always_comb begin
    pick  = rr_pick(valid, ptr);
    found = pick[2];
    idx   = pick[1:0];
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 WIDTH-bit data mux.
//
// Four producer lanes offer valid/data/last beats. One lane is granted at a time and the
// grant is held for a whole packet (first beat through last=1). The granted beat is
// registered into a single-entry output buffer with a valid/ready handshake; a beat can
// be loaded in the same cycle the previous one drains, so one beat per cycle is sustained.
//
// Parameters:
//   WIDTH  data width of each lane and of the output
//   CNT_W  width of each per-requester packet counter (counter build only)
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-low reset
//   in_valid      in   [4]     per-lane beat valid
//   in_last       in   [4]     per-lane end-of-packet flag
//   in_data0..3   in   [WIDTH] per-lane data
//   in_ready      out  [4]     one-hot or zero grant/accept
//   out_valid     out          output buffer holds a beat
//   out_ready     in           consumer accepts the buffered beat
//   out_data      out  [WIDTH] buffered beat data
//   out_last      out          buffered beat last flag
//   out_sel       out  [2]     source lane of the buffered beat
//   locked        out          arbiter is mid-packet (LOCK state)
//   grant_cnt     out  [4*CNT_W] packets completed per lane (MUX4_ARB_GRANT_CNT_EN only)
//   cnt_clr       in           clear all counters (MUX4_ARB_GRANT_CNT_EN only)
//
// Build option: define MUX4_ARB_GRANT_CNT_EN to add the saturating per-lane packet
// counters together with the grant_cnt and cnt_clr ports.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ-1:0]       in_last,
  input  logic [WIDTH-1:0]       in_data0,
  input  logic [WIDTH-1:0]       in_data1,
  input  logic [WIDTH-1:0]       in_data2,
  input  logic [WIDTH-1:0]       in_data3,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [1:0]             out_sel,
`ifdef MUX4_ARB_GRANT_CNT_EN
  output logic [N_REQ*CNT_W-1:0] grant_cnt,
  input  logic                   cnt_clr,
`endif
  output logic                   locked
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [1:0]       out_sel_q, out_sel_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             can_load;
  logic             grant_ok;
  logic [1:0]       sel;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             xfer;

  mux4_rr_pick u_pick (
    .valid (in_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The buffer may take a beat when empty or when its current beat leaves this cycle.
  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    sel      = pick_idx;
    grant_ok = pick_found;
    if (state_q == LOCK) begin
      // Mid-packet only the owner may proceed, whether or not it is currently valid.
      sel      = owner_q;
      grant_ok = 1'b1;
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset && grant_ok) begin
      in_ready[sel] = can_load;
    end
  end

  assign xfer = in_valid[sel] && in_ready[sel];

  // Shared 4:1 data mux steered by the combinational select.
  always_comb begin
    sel_data = '0;
    unique case (sel)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      2'd3:    sel_data = in_data3;
      default: sel_data = '0;
    endcase
    sel_last = in_last[sel];
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_sel_d   = sel;
      if (sel_last) begin
        // Packet complete: release the grant and rotate priority past this lane.
        state_d = ARB;
        ptr_d   = sel + 2'd1;
      end else begin
        state_d = LOCK;
        owner_d = sel;
      end
    end else if (out_ready) begin
      // Drain with nothing to replace it; payload registers keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ARB;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign locked    = (state_q == LOCK);

  // ---------------------------------------------------------------------------
  // Optional per-lane completed-packet counters
  // ---------------------------------------------------------------------------
`ifdef MUX4_ARB_GRANT_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        // Clear takes priority over a completion in the same cycle.
        cnt_d[i] = '0;
      end else if (xfer && sel_last && (sel == 2'(i)) && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter. Expected output beats are queued as stimulus
// is driven and compared by a monitor whenever the consumer takes a beat; each scenario
// task also checks grants and status inline.
module tb_mux4_rr_arbiter;

  localparam int unsigned WIDTH = 8;
`ifdef MUX4_ARB_GRANT_CNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 8;
`endif

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             clock;
  logic             reset;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             locked;
`ifdef MUX4_ARB_GRANT_CNT_EN
  logic [4*CNT_W-1:0] grant_cnt;
  logic               cnt_clr;
`endif

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];

  mux4_rr_arbiter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
`ifdef MUX4_ARB_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
    .cnt_clr   (cnt_clr),
`endif
    .locked    (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed so far)",
             n_pass, n_checks);
    $fatal(1);
  end

  // Scoreboard monitor: a beat is consumed at the edge following a negedge where
  // out_valid & out_ready hold.
  always @(negedge clock) begin
    beat_t got;
    beat_t want;
    if (reset && out_valid && out_ready) begin
      got = '{sel: out_sel, data: out_data, last: out_last};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got sel=%0d data=%h last=%b, required no beat",
                 got.sel, got.data, got.last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          $display("FAIL beat: got sel=%0d data=%h last=%b, required sel=%0d data=%h last=%b",
                   got.sel, got.data, got.last, want.sel, want.data, want.last);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic push(input logic [1:0] s, input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b = '{sel: s, data: d, last: l};
    exp_q.push_back(b);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d beats still outstanding, required 0", name, exp_q.size());
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    in_data0  = 8'h11;
    in_data1  = 8'h22;
    in_data2  = 8'h33;
    in_data3  = 8'h44;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({in_ready, out_valid, out_sel, locked, out_data} !== {4'b0, 1'b0, 2'd0, 1'b0, 8'h00}) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_sel=%0d locked=%b out_data=%h, required 0000 0 0 0 00",
               in_ready, out_valid, out_sel, locked, out_data);
    end else begin
      n_pass++;
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0001) begin
      $display("FAIL reset_first_grant: in_ready=%b, required 0001", in_ready);
    end else begin
      n_pass++;
    end
    in_valid = 4'h0;  // withdraw before the edge so nothing transfers
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    next_cycle();
    in_data0 = 8'hA0;
    in_data1 = 8'hA1;
    in_data2 = 8'hA2;
    in_data3 = 8'hA3;
    in_last  = 4'hF;
    in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      push(2'(k % 4), 8'hA0 + 8'(k % 4), 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      want = 4'b0001 << (k % 4);
      n_checks++;
      if (in_ready !== want) begin
        $display("FAIL fair_grant[%0d]: in_ready=%b, required %b", k, in_ready, want);
      end else begin
        n_pass++;
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          $display("FAIL fair_no_bubble[%0d]: out_valid=%b, required 1", k, out_valid);
        end else begin
          n_pass++;
        end
      end
      next_cycle();
    end
    in_valid = 4'h0;
    wait_drain("fair");
  endtask

  task automatic test_packet_lock();
    // Priority pointer is 1 after the fairness run, so lane 2 wins first.
    logic [3:0] v_t   [5] = '{4'b1101, 4'b1101, 4'b1101, 4'b1001, 4'b1001};
    logic [3:0] l_t   [5] = '{4'b1001, 4'b1001, 4'b1101, 4'b1001, 4'b1001};
    logic [7:0] d2_t  [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC2, 8'hC2};
    logic [3:0] rdy_t [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    logic       lck_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    next_cycle();
    in_data0 = 8'hB0;
    in_data3 = 8'hB3;
    push(2'd2, 8'hC0, 1'b0);
    push(2'd2, 8'hC1, 1'b0);
    push(2'd2, 8'hC2, 1'b1);
    push(2'd3, 8'hB3, 1'b1);
    push(2'd0, 8'hB0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = v_t[k];
      in_last  = l_t[k];
      in_data2 = d2_t[k];
      @(negedge clock);
      n_checks++;
      if ({in_ready, locked} !== {rdy_t[k], lck_t[k]}) begin
        $display("FAIL lock_cycle[%0d]: in_ready=%b locked=%b, required in_ready=%b locked=%b",
                 k, in_ready, locked, rdy_t[k], lck_t[k]);
      end else begin
        n_pass++;
      end
      next_cycle();
    end
    in_valid = 4'h0;
    wait_drain("lock");
  endtask

  task automatic test_backpressure();
    next_cycle();
    in_valid  = 4'b0010;
    in_last   = 4'b0010;
    in_data1  = 8'hD1;
    out_ready = 1'b1;
    push(2'd1, 8'hD1, 1'b1);
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL bp_first_grant: in_ready=%b, required 0010", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    out_ready = 1'b0;
    in_data1  = 8'hD2;
    push(2'd1, 8'hD2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_checks++;
      if ({in_ready, out_valid, out_sel, out_data} !== {4'b0000, 1'b1, 2'd1, 8'hD1}) begin
        $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b out_sel=%0d out_data=%h, required 0000 1 1 d1",
                 k, in_ready, out_valid, out_sel, out_data);
      end else begin
        n_pass++;
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL bp_release: in_ready=%b, required 0010", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    in_valid = 4'h0;
    wait_drain("bp");
  endtask

  task automatic test_owner_stall();
    // Pointer is 2 here; lane 1 is the only requester so it wins and locks.
    next_cycle();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    in_data1 = 8'hE1;
    push(2'd1, 8'hE1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL stall_first_grant: in_ready=%b, required 0010", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    in_data0 = 8'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++;
      if ({in_ready, locked} !== {4'b0010, 1'b1}) begin
        $display("FAIL stall_hold[%0d]: in_ready=%b locked=%b, required in_ready=0010 locked=1",
                 k, in_ready, locked);
      end else begin
        n_pass++;
      end
      next_cycle();
    end
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    in_data1 = 8'hE2;
    push(2'd1, 8'hE2, 1'b1);
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL stall_finish: in_ready=%b, required 0010", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    in_valid = 4'h0;
    @(negedge clock);
    n_checks++;
    if (locked !== 1'b0) begin
      $display("FAIL stall_unlock: locked=%b, required 0", locked);
    end else begin
      n_pass++;
    end
    wait_drain("stall");
  endtask

  task automatic test_reset_mid_packet();
    // Pointer is 2; lane 3 opens a packet, then reset abandons it.
    next_cycle();
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    in_data3 = 8'h77;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b1000) begin
      $display("FAIL midrst_grant: in_ready=%b, required 1000", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    reset    = 1'b0;
    in_valid = 4'h0;
    next_cycle();
    @(negedge clock);
    n_checks++;
    if ({out_valid, locked, in_ready} !== {1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL midrst_state: out_valid=%b locked=%b in_ready=%b, required 0 0 0000",
               out_valid, locked, in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    reset    = 1'b1;
    in_valid = 4'b0010;
    in_last  = 4'b0010;
    in_data1 = 8'hF1;
    push(2'd1, 8'hF1, 1'b1);
    @(negedge clock);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      $display("FAIL midrst_after: in_ready=%b, required 0010", in_ready);
    end else begin
      n_pass++;
    end
    next_cycle();
    in_valid = 4'h0;
    wait_drain("midrst");
  endtask

`ifdef MUX4_ARB_GRANT_CNT_EN
  task automatic test_counters();
    int want;
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    @(negedge clock);
    n_checks++;
    if (grant_cnt[1:0] !== 2'd0) begin
      $display("FAIL cnt_clear: grant_cnt[0]=%0d, required 0", grant_cnt[1:0]);
    end else begin
      n_pass++;
    end
    next_cycle();
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      in_data0 = 8'h10 + 8'(k);
      push(2'd0, 8'h10 + 8'(k), 1'b1);
      want = (k > 3) ? 3 : k;
      @(negedge clock);
      n_checks++;
      if (grant_cnt[1:0] !== 2'(want)) begin
        $display("FAIL cnt_count[%0d]: grant_cnt[0]=%0d, required %0d", k, grant_cnt[1:0], want);
      end else begin
        n_pass++;
      end
      next_cycle();
    end
    in_data0 = 8'h20;
    cnt_clr  = 1'b1;
    push(2'd0, 8'h20, 1'b1);
    @(negedge clock);
    n_checks++;
    if (grant_cnt[1:0] !== 2'd3) begin
      $display("FAIL cnt_saturate: grant_cnt[0]=%0d, required 3", grant_cnt[1:0]);
    end else begin
      n_pass++;
    end
    next_cycle();
    cnt_clr  = 1'b0;
    in_valid = 4'h0;
    @(negedge clock);
    n_checks++;
    if (grant_cnt[1:0] !== 2'd0) begin
      $display("FAIL cnt_clr_wins: grant_cnt[0]=%0d, required 0", grant_cnt[1:0]);
    end else begin
      n_pass++;
    end
    wait_drain("cnt");
  endtask
`endif

  initial begin
`ifdef MUX4_ARB_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_owner_stall();
    test_reset_mid_packet();
`ifdef MUX4_ARB_GRANT_CNT_EN
    test_counters();
`endif
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 WIDTH-bit data mux.
- Four requesters present valid/data/last beats; the block chooses one, drives the mux select and registers the selected beat into a 1-entry output buffer with a valid/ready handshake.
- A grant stays locked to one requester for a whole packet, from its first beat through the beat with last=1.
- Sits between producer lanes and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each lane and of the output.
- CNT_W, 8, width of the per-requester grant counters (optional feature only).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- in_valid  in  4  per-requester beat valid.
- in_last  in  4  per-requester end-of-packet flag, qualified by in_valid.
- in_data0..in_data3  in  WIDTH each  requester data.
- in_ready  out  4  one-hot or zero; a beat transfers when in_valid[i] & in_ready[i].
- out_valid  out  1  output buffer holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  WIDTH  buffered beat.
- out_last  out  1  buffered last flag.
- out_sel  out  2  requester index of the buffered beat.
- locked  out  1  arbiter is in LOCK state.

Behaviour:
- Reset (reset==0 at an edge): out_valid=0, out_data=0, out_last=0, out_sel=0, state=ARB, rr pointer ptr=0, owner=0, locked=0.
- While reset is held, in_ready=0.
- Buffer free condition: can_load = !out_valid | out_ready.
  - Full throughput: one beat per cycle is sustainable.
  - in_ready depends combinationally on out_ready.
- State ARB:
  - Winner = first i with in_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - in_ready[winner]=can_load; all other in_ready bits are 0.
  - If no in_valid bit is set, in_ready=0.
  - On transfer with in_last=1: stay in ARB, ptr=winner+1 mod 4.
  - On transfer with in_last=0: go to LOCK, owner=winner, ptr unchanged.
- State LOCK:
  - Only owner is eligible: in_ready[owner]=can_load; other requesters are ignored even if valid.
  - On transfer with in_last=1: go to ARB, ptr=owner+1 mod 4.
  - locked=1 throughout LOCK.
- Transfer effect:
  - Next cycle out_valid=1, out_data=in_data[g], out_last=in_last[g], out_sel=g.
  - Latency from input handshake to out_valid is 1 cycle.
- Drain: out_valid & out_ready with no new transfer gives out_valid=0 next cycle. out_data, out_sel and out_last keep their last values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one; out_valid stays 1 with no bubble.
- out_valid=1 & out_ready=0: out_data, out_last and out_sel are held stable, and in_ready=0.
- Owner drops in_valid mid-packet: stay in LOCK indefinitely; no other requester is granted.
- Reset asserted mid-packet: everything returns to reset values. A partial packet is abandoned and never flushed.
- Mux select:
  - Registered out_sel identifies the source of the buffered beat.
  - The combinational select feeding the 4:1 mux is the winner index (ARB) or owner (LOCK).

Optional Feature:
- Macro: MUX4_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt (4*CNT_W bits); slice i counts packets completed by requester i, i.e. transfers with in_last=1.
  - Counters saturate at 2^CNT_W-1 and are cleared by reset.
  - Adds input cnt_clr (1 bit), which clears all counters synchronously. cnt_clr wins over an increment in the same cycle.
- Undefined: no counters, no grant_cnt or cnt_clr ports; all other behaviour is identical.

Decomposition:
- Shared package mux4_arb_pkg holds:
  - arb_state_e enum {ARB, LOCK};
  - localparam N_REQ=4;
  - function rr_pick(valid[3:0], ptr[1:0]) returning {found, idx[1:0]}.
- One sub-module is natural: mux4_rr_pick, the purely combinational rotate-priority encoder. The FSM, buffer and counters stay in the top.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with all in_valid=1.
  - Required: in_ready=0, out_valid=0, out_sel=0, locked=0.
  - After release with ptr=0: requester 0 is granted first.
- Single-beat fairness:
  - Stimulus: all 4 requesters valid with last=1, data 0xA0..0xA3, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Packet lock:
  - Stimulus: requester 2 sends 3 beats (last on the 3rd) while requesters 0 and 3 are valid.
  - Required: out_sel=2 for 3 consecutive beats and locked=1 during them; next grant goes to 3, then 0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a beat buffered.
  - Required: out_data and out_sel stable, in_ready=0. When out_ready returns to 1, the next beat appears the following cycle with no loss or duplication.
- Owner stall: requester 1 sends a non-last beat then drops valid for 4 cycles while requester 0 is valid -> in_ready[0]=0 throughout and locked=1.
- Counters (MUX4_ARB_GRANT_CNT_EN, CNT_W=2):
  - Stimulus: requester 0 completes 5 packets.
  - Required: grant_cnt slice 0 saturates at 3. Asserting cnt_clr in the same cycle as a completion gives 0.
